// File: rtl/axi4l_pkg.sv
// Shared types and response codes for the AXI4-Lite write master.
package axi4l_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RESP = 2'd2
  } wr_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4l_write_master.sv
// Turns single user write requests into AXI4-Lite AW/W/B transactions,
// one outstanding write at a time; requests arriving while busy are dropped.
module axi4l_write_master
  import axi4l_pkg::*;
#(
  parameter int WIDTH_ADDR = 32,
  parameter int WIDTH_DATA = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write_en,
  input  logic [WIDTH_ADDR-1:0]   write_addr_in,
  input  logic [WIDTH_DATA-1:0]   write_data_in,
  input  logic [WIDTH_DATA/8-1:0] strobe_in,
  output logic                    write_done,
  output logic [1:0]              write_resp,
  output logic                    write_busy,
  output logic                    write_drop,
  output logic [WIDTH_ADDR-1:0]   awaddr,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [WIDTH_DATA-1:0]   wdata,
  output logic [WIDTH_DATA/8-1:0] wstrb,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  wr_state_t state;
  logic      aw_done;
  logic      w_done;
  logic      aw_hs;
  logic      w_hs;

  assign aw_hs      = awvalid & awready;
  assign w_hs       = wvalid & wready;
  assign awprot     = 3'b000;
  assign write_busy = (state != IDLE);

  // AW and W complete independently; the flags remember an earlier handshake
  // so RESP is entered once both channels have finished, in any order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      awaddr     <= '0;
      wdata      <= '0;
      wstrb      <= '0;
      write_done <= 1'b0;
      write_drop <= 1'b0;
      write_resp <= RESP_OKAY;
    end else begin
      write_done <= 1'b0;
      write_drop <= 1'b0;
      unique case (state)
        IDLE: begin
          if (write_en) begin
            awaddr  <= write_addr_in;
            wdata   <= write_data_in;
            wstrb   <= strobe_in;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= SEND;
          end
        end
        SEND: begin
          write_drop <= write_en;
          if (aw_hs) awvalid <= 1'b0;
          if (w_hs)  wvalid  <= 1'b0;
          if ((aw_done | aw_hs) && (w_done | w_hs)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bready  <= 1'b1;
            state   <= RESP;
          end else begin
            aw_done <= aw_done | aw_hs;
            w_done  <= w_done | w_hs;
          end
        end
        RESP: begin
          write_drop <= write_en;
          if (bvalid && bready) begin
            bready     <= 1'b0;
            write_resp <= bresp;
            write_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4l_write_master.sv
// Directed bench for axi4l_write_master; outputs are checked 1ns after each rising edge.
module tb_axi4l_write_master;
  import axi4l_pkg::*;

  logic        clk;
  logic        reset;
  logic        write_en;
  logic [31:0] write_addr_in;
  logic [31:0] write_data_in;
  logic [3:0]  strobe_in;
  logic        write_done;
  logic [1:0]  write_resp;
  logic        write_busy;
  logic        write_drop;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int checks   = 0;
  int failures = 0;

  axi4l_write_master #(.WIDTH_ADDR(32), .WIDTH_DATA(32)) dut (
    .clk(clk), .reset(reset), .write_en(write_en),
    .write_addr_in(write_addr_in), .write_data_in(write_data_in), .strobe_in(strobe_in),
    .write_done(write_done), .write_resp(write_resp), .write_busy(write_busy),
    .write_drop(write_drop), .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid),
    .awready(awready), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb);
    write_en      = en;
    write_addr_in = addr;
    write_data_in = data;
    strobe_in     = strb;
  endtask

  task automatic slave(input logic awr, input logic wr, input logic bv, input logic [1:0] br);
    awready = awr;
    wready  = wr;
    bvalid  = bv;
    bresp   = br;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
    slave(1'b1, 1'b1, 1'b1, RESP_OKAY);
    tick();
    tick();
    checkOutput("rst_awvalid", awvalid, 0);
    checkOutput("rst_wvalid", wvalid, 0);
    checkOutput("rst_bready", bready, 0);
    checkOutput("rst_done", write_done, 0);
    checkOutput("rst_drop", write_drop, 0);
    checkOutput("rst_resp", write_resp, 0);
    checkOutput("rst_busy", write_busy, 0);
    checkOutput("rst_awaddr", awaddr, 0);
    checkOutput("rst_awprot", awprot, 0);
    reset = 1'b0;

    // 1: single write, all-ready slave
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("t1_awvalid", awvalid, 1);
    checkOutput("t1_wvalid", wvalid, 1);
    checkOutput("t1_awaddr", awaddr, 32'h10);
    checkOutput("t1_wdata", wdata, 32'hDEADBEEF);
    checkOutput("t1_wstrb", wstrb, 4'hF);
    checkOutput("t1_busy", write_busy, 1);
    tick();
    checkOutput("t1_aw_cleared", awvalid, 0);
    checkOutput("t1_w_cleared", wvalid, 0);
    checkOutput("t1_bready", bready, 1);
    tick();
    checkOutput("t1_done", write_done, 1);
    checkOutput("t1_resp", write_resp, RESP_OKAY);
    checkOutput("t1_busy_low", write_busy, 0);
    tick();
    checkOutput("t1_done_pulse", write_done, 0);

    // 2: awready delayed, W finishes first
    slave(1'b0, 1'b1, 1'b1, RESP_OKAY);
    applyStimulus(1'b1, 32'h24, 32'h11223344, 4'h3);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("t2_awvalid0", awvalid, 1);
    tick();
    checkOutput("t2_w_first", wvalid, 0);
    checkOutput("t2_awvalid1", awvalid, 1);
    checkOutput("t2_no_bready1", bready, 0);
    tick();
    checkOutput("t2_awvalid2", awvalid, 1);
    tick();
    checkOutput("t2_awvalid3", awvalid, 1);
    checkOutput("t2_awaddr_stable", awaddr, 32'h24);
    checkOutput("t2_no_bready3", bready, 0);
    checkOutput("t2_no_done", write_done, 0);
    awready = 1'b1;
    tick();
    checkOutput("t2_aw_cleared", awvalid, 0);
    checkOutput("t2_bready", bready, 1);
    tick();
    checkOutput("t2_done", write_done, 1);
    checkOutput("t2_wstrb", wstrb, 4'h3);
    tick();
    checkOutput("t2_done_once", write_done, 0);

    // 3: slow SLVERR response
    slave(1'b1, 1'b1, 1'b0, RESP_SLVERR);
    applyStimulus(1'b1, 32'h34, 32'hCAFEF00D, 4'hF);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    checkOutput("t3_bready", bready, 1);
    tick();
    tick();
    tick();
    checkOutput("t3_wait_busy", write_busy, 1);
    checkOutput("t3_wait_done", write_done, 0);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    checkOutput("t3_done", write_done, 1);
    checkOutput("t3_resp", write_resp, RESP_SLVERR);
    checkOutput("t3_busy_low", write_busy, 0);
    checkOutput("t3_bready_low", bready, 0);
    tick();
    checkOutput("t3_done_pulse", write_done, 0);

    // 4: request while in SEND is dropped
    slave(1'b0, 1'b0, 1'b0, RESP_OKAY);
    applyStimulus(1'b1, 32'h10, 32'hAAAA5555, 4'hF);
    tick();
    applyStimulus(1'b1, 32'h20, 32'h12345678, 4'h1);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("t4_drop", write_drop, 1);
    checkOutput("t4_awaddr_kept", awaddr, 32'h10);
    checkOutput("t4_wdata_kept", wdata, 32'hAAAA5555);
    tick();
    checkOutput("t4_drop_pulse", write_drop, 0);
    slave(1'b1, 1'b1, 1'b1, RESP_OKAY);
    tick();
    checkOutput("t4_bready", bready, 1);
    tick();
    checkOutput("t4_done", write_done, 1);
    tick();
    checkOutput("t4_done_once_a", write_done, 0);
    tick();
    checkOutput("t4_done_once_b", write_done, 0);
    checkOutput("t4_idle", write_busy, 0);

    // 5: back-to-back, second request issued in the write_done cycle
    applyStimulus(1'b1, 32'h30, 32'h00000030, 4'hF);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    checkOutput("t5_done_a", write_done, 1);
    applyStimulus(1'b1, 32'h40, 32'h00000040, 4'hC);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("t5_done_a_pulse", write_done, 0);
    checkOutput("t5_accept_b", awvalid, 1);
    checkOutput("t5_awaddr_b", awaddr, 32'h40);
    checkOutput("t5_drop_none", write_drop, 0);
    tick();
    tick();
    checkOutput("t5_done_b", write_done, 1);
    checkOutput("t5_wstrb_b", wstrb, 4'hC);
    tick();

    // 6: reset while waiting in RESP
    slave(1'b1, 1'b1, 1'b0, RESP_OKAY);
    applyStimulus(1'b1, 32'h44, 32'h0BADC0DE, 4'hF);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    checkOutput("t6_in_resp", bready, 1);
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_bready", bready, 0);
    checkOutput("t6_rst_awvalid", awvalid, 0);
    checkOutput("t6_rst_busy", write_busy, 0);
    bvalid = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checkOutput("t6_no_done", write_done, 0);
    bvalid = 1'b0;
    applyStimulus(1'b1, 32'h50, 32'h55555555, 4'hF);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0);
    checkOutput("t6_accept", awvalid, 1);
    checkOutput("t6_awaddr", awaddr, 32'h50);
    bvalid = 1'b1;
    tick();
    tick();
    checkOutput("t6_done", write_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
